// File: rtl/bk_pkg.sv
// Shared definitions for the Brent-Kung adder family: slice width,
// multi-word limits and the sequencer state encoding.
package bk_pkg;

    localparam int BK_SLICE_W      = 32;
    localparam int BK_MW_MAX_WORDS = 16;
    localparam int BK_MW_IDX_W     = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } bk_mw_state_t;

endpackage

// File: rtl/bk_multiword_adder_if.sv
// Request/response bundle for bk_multiword_adder.
// The sub signal exists only when BK_MWADD_SUB_EN is defined.
interface bk_multiword_adder_if
    import bk_pkg::*;
#(
    parameter int WORDS = 4
);

    logic                        in_valid;
    logic                        in_ready;
    logic [WORDS*BK_SLICE_W-1:0] a;
    logic [WORDS*BK_SLICE_W-1:0] b;
    logic                        cin;
`ifdef BK_MWADD_SUB_EN
    logic                        sub;
`endif
    logic                        out_valid;
    logic                        out_ready;
    logic [WORDS*BK_SLICE_W-1:0] sum;
    logic                        cout;
    logic                        ovf;

    modport master (
        output in_valid, a, b, cin,
`ifdef BK_MWADD_SUB_EN
        output sub,
`endif
        output out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin,
`ifdef BK_MWADD_SUB_EN
        input  sub,
`endif
        input  out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

endinterface

// File: rtl/bk_adder_32bit.sv
// 32-bit Brent-Kung parallel-prefix adder core (combinational).
module bk_adder_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    logic [31:0] gg;
    logic [31:0] pp;

    // Prefix tree: up-sweep builds power-of-two spans, down-sweep fills the gaps;
    // cin is folded into bit 0's generate so gg[i] is the carry out of bit i.
    always_comb begin
        gg    = a & b;
        pp    = a ^ b;
        gg[0] = gg[0] | (pp[0] & cin);
        for (int unsigned lvl = 0; lvl < 5; lvl++) begin
            for (int unsigned i = (2 << lvl) - 1; i < 32; i += (2 << lvl)) begin
                gg[5'(i)] = gg[5'(i)] | (pp[5'(i)] & gg[5'(i - (1 << lvl))]);
                pp[5'(i)] = pp[5'(i)] & pp[5'(i - (1 << lvl))];
            end
        end
        for (int unsigned k = 0; k < 4; k++) begin
            for (int unsigned i = 3 * (1 << (3 - k)) - 1; i < 32; i += (2 << (3 - k))) begin
                gg[5'(i)] = gg[5'(i)] | (pp[5'(i)] & gg[5'(i - (1 << (3 - k)))]);
                pp[5'(i)] = pp[5'(i)] & pp[5'(i - (1 << (3 - k)))];
            end
        end
        sum  = (a ^ b) ^ {gg[30:0], cin};
        cout = gg[31];
    end

endmodule

// File: rtl/bk_multiword_adder.sv
// Sequential WORDS x 32-bit adder: one slice per cycle through a single
// bk_adder_32bit, carry rippled through carry_q.
// Optional subtract support is enabled by defining BK_MWADD_SUB_EN.
module bk_multiword_adder
    import bk_pkg::*;
#(
    parameter int WORDS = 4,
    parameter int WIDTH = BK_SLICE_W
) (
    input logic                 clk,
    input logic                 rst_n,
    bk_multiword_adder_if.slave bus
);

    localparam int                     TOTAL_W  = WORDS * WIDTH;
    localparam logic [BK_MW_IDX_W-1:0] LAST_IDX = BK_MW_IDX_W'(WORDS - 1);

    bk_mw_state_t           state_q, state_d;
    logic [BK_MW_IDX_W-1:0] idx_q;
    logic [TOTAL_W-1:0]     a_q, beff_q, sum_q;
    logic                   carry_q, cout_q, ovf_q;
    logic [TOTAL_W-1:0]     beff_in;
    logic                   carry_in;
    logic [WIDTH-1:0]       a_slice, b_slice, core_sum;
    logic                   core_cout;
    logic                   accept;

`ifdef BK_MWADD_SUB_EN
    assign beff_in  = bus.sub ? ~bus.b : bus.b;
    assign carry_in = bus.cin ^ bus.sub;
`else
    assign beff_in  = bus.b;
    assign carry_in = bus.cin;
`endif

    assign accept        = bus.in_valid && (state_q == IDLE);
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;

    // Select the operand slice addressed by idx_q for the shared core.
    always_comb begin
        a_slice = '0;
        b_slice = '0;
        for (int unsigned w = 0; w < WORDS; w++) begin
            if (idx_q == BK_MW_IDX_W'(w)) begin
                a_slice = a_q[w*WIDTH +: WIDTH];
                b_slice = beff_q[w*WIDTH +: WIDTH];
            end
        end
    end

    bk_adder_32bit u_core (
        .a    (a_slice),
        .b    (b_slice),
        .cin  (carry_q),
        .sum  (core_sum),
        .cout (core_cout)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)            state_d = RUN;
            RUN:     if (idx_q == LAST_IDX) state_d = DONE;
            DONE:    if (bus.out_ready)     state_d = IDLE;
            default:                        state_d = IDLE;
        endcase
    end

    // Operand capture, slice-by-slice accumulation and final flag capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            beff_q  <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q     <= bus.a;
                        beff_q  <= beff_in;
                        carry_q <= carry_in;
                        idx_q   <= '0;
                    end
                end
                RUN: begin
                    for (int unsigned w = 0; w < WORDS; w++) begin
                        if (idx_q == BK_MW_IDX_W'(w)) sum_q[w*WIDTH +: WIDTH] <= core_sum;
                    end
                    carry_q <= core_cout;
                    idx_q   <= idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        cout_q <= core_cout;
                        ovf_q  <= (a_slice[WIDTH-1] == b_slice[WIDTH-1]) &&
                                  (core_sum[WIDTH-1] != a_slice[WIDTH-1]);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bk_multiword_adder.sv
// Directed-vector bench for bk_multiword_adder with WORDS=4.
// Subtract vectors are included when BK_MWADD_SUB_EN is defined.
module tb_bk_multiword_adder;

    typedef struct packed {
        logic [127:0] a;
        logic [127:0] b;
        logic         ci;
        logic [127:0] s;
        logic         co;
        logic         ov;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   vectors    = 0;
    int   miscompares = 0;
`ifdef BK_MWADD_SUB_EN
    logic sub_sel = 1'b0;
`endif

    always #5 clk = ~clk;

    bk_multiword_adder_if #(.WORDS(4)) bus ();

    bk_multiword_adder #(.WORDS(4), .WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Present one request, wait for the accepting edge, then count edges
    // until out_valid (lat = -1 when the bound expires).
    task automatic run_op(input logic [127:0] av, input logic [127:0] bv,
                          input logic ci, output int lat);
        bus.a  = av;
        bus.b  = bv;
        bus.cin = ci;
`ifdef BK_MWADD_SUB_EN
        bus.sub = sub_sel;
`endif
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        if (bus.out_valid !== 1'b1) lat = -1;
    endtask

    task automatic handoff();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        vectors++; if (bus.sum !== 128'h0) begin miscompares++; $display("FAIL reset_sum: got %h want 0", bus.sum); end
        vectors++; if ({bus.cout, bus.ovf} !== 2'b00) begin miscompares++; $display("FAIL reset_flags: got %b want 00", {bus.cout, bus.ovf}); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        vectors++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL post_reset_handshake: got rdy=%b vld=%b want 1/0", bus.in_ready, bus.out_valid); end
    endtask

    task automatic test_add_vectors();
        vec_t tbl[6];
        int   lat;
        tbl[0] = '{a: '1, b: 128'h1, ci: 1'b0, s: 128'h0, co: 1'b1, ov: 1'b0};
        tbl[1] = '{a: 128'h00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, b: 128'h1, ci: 1'b0,
                   s: 128'h00000001_00000000_00000000_00000000, co: 1'b0, ov: 1'b0};
        tbl[2] = '{a: 128'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, b: 128'h1, ci: 1'b0,
                   s: 128'h80000000_00000000_00000000_00000000, co: 1'b0, ov: 1'b1};
        tbl[3] = '{a: 128'h12345678_9ABCDEF0_0FEDCBA9_87654321, b: 128'h11111111_11111111_11111111_11111111, ci: 1'b1,
                   s: 128'h23456789_ABCDF001_20FEDCBA_98765433, co: 1'b0, ov: 1'b0};
        tbl[4] = '{a: 128'h0, b: '1, ci: 1'b1, s: 128'h0, co: 1'b1, ov: 1'b0};
        tbl[5] = '{a: 128'h80000000_00000000_00000000_00000000, b: 128'h80000000_00000000_00000000_00000000, ci: 1'b0,
                   s: 128'h0, co: 1'b1, ov: 1'b1};
        for (int i = 0; i < 6; i++) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].ci, lat);
            vectors++; if (lat !== 4) begin miscompares++; $display("FAIL add%0d_latency: got %0d want 4", i, lat); end
            vectors++; if (bus.sum !== tbl[i].s) begin miscompares++; $display("FAIL add%0d_sum: got %h want %h", i, bus.sum, tbl[i].s); end
            vectors++; if (bus.cout !== tbl[i].co) begin miscompares++; $display("FAIL add%0d_cout: got %b want %b", i, bus.cout, tbl[i].co); end
            vectors++; if (bus.ovf !== tbl[i].ov) begin miscompares++; $display("FAIL add%0d_ovf: got %b want %b", i, bus.ovf, tbl[i].ov); end
            vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL add%0d_in_ready_done: got %b want 0", i, bus.in_ready); end
            handoff();
            vectors++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL add%0d_handoff: got vld=%b rdy=%b want 0/1", i, bus.out_valid, bus.in_ready); end
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] exp_s;
        int           lat;
        exp_s = 128'h23456789_ABCDF001_20FEDCBA_98765433;
        run_op(128'h12345678_9ABCDEF0_0FEDCBA9_87654321, 128'h11111111_11111111_11111111_11111111, 1'b1, lat);
        vectors++; if (lat !== 4) begin miscompares++; $display("FAIL hold_latency: got %0d want 4", lat); end
        bus.a = 128'h5;
        bus.b = 128'h7;
        bus.cin = 1'b0;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            vectors++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL hold_handshake c%0d: got vld=%b rdy=%b want 1/0", c, bus.out_valid, bus.in_ready); end
            vectors++; if (bus.sum !== exp_s || bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin miscompares++; $display("FAIL hold_result c%0d: got %h/%b/%b want %h/0/0", c, bus.sum, bus.cout, bus.ovf, exp_s); end
        end
        handoff();
        vectors++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_idle_cycle: got vld=%b rdy=%b want 0/1", bus.out_valid, bus.in_ready); end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_accept: got rdy=%b want 0", bus.in_ready); end
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        vectors++; if (lat !== 4) begin miscompares++; $display("FAIL b2b_latency: got %0d want 4", lat); end
        vectors++; if (bus.sum !== 128'hC || bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin miscompares++; $display("FAIL b2b_result: got %h/%b/%b want c/0/0", bus.sum, bus.cout, bus.ovf); end
        handoff();
    endtask

    task automatic test_reset_midop();
        int lat;
        bus.a = '1;
        bus.b = 128'h1;
        bus.cin = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        vectors++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL midreset_handshake: got vld=%b rdy=%b want 0/1", bus.out_valid, bus.in_ready); end
        vectors++; if (bus.sum !== 128'h0) begin miscompares++; $display("FAIL midreset_sum: got %h want 0", bus.sum); end
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            vectors++; if (bus.out_valid !== 1'b0 || bus.sum !== 128'h0 || bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL midreset_quiet c%0d: got vld=%b rdy=%b sum=%h want 0/1/0", c, bus.out_valid, bus.in_ready, bus.sum); end
        end
        run_op(128'h00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'h1, 1'b0, lat);
        vectors++; if (lat !== 4) begin miscompares++; $display("FAIL midreset_next_latency: got %0d want 4", lat); end
        vectors++; if (bus.sum !== 128'h00000001_00000000_00000000_00000000 || bus.cout !== 1'b0) begin miscompares++; $display("FAIL midreset_next_result: got %h/%b want 00000001000000000000000000000000/0", bus.sum, bus.cout); end
        handoff();
    endtask

`ifdef BK_MWADD_SUB_EN
    task automatic test_sub();
        int lat;
        sub_sel = 1'b1;
        run_op(128'h0, 128'h1, 1'b0, lat);
        vectors++; if (lat !== 4) begin miscompares++; $display("FAIL sub0_latency: got %0d want 4", lat); end
        vectors++; if (bus.sum !== {128{1'b1}} || bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin miscompares++; $display("FAIL sub0_result: got %h/%b/%b want all-ones/0/0", bus.sum, bus.cout, bus.ovf); end
        handoff();
        run_op(128'h5, 128'h5, 1'b0, lat);
        vectors++; if (bus.sum !== 128'h0 || bus.cout !== 1'b1 || bus.ovf !== 1'b0) begin miscompares++; $display("FAIL sub1_result: got %h/%b/%b want 0/1/0", bus.sum, bus.cout, bus.ovf); end
        handoff();
        sub_sel = 1'b0;
    endtask
`endif

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
`ifdef BK_MWADD_SUB_EN
        bus.sub       = 1'b0;
`endif
        test_reset();
        test_add_vectors();
        test_back_to_back();
        test_reset_midop();
`ifdef BK_MWADD_SUB_EN
        test_sub();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
